shift_restore: RTL and testbench

- Sequential inverse of the combinational shifter: takes a word that was shifted or rotated in the forward direction and moves it back by the same amount.
- Moves up to STEP positions per cycle.
- Operand enters through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Sits downstream of a shifter stage in datapaths where area matters more than latency.

---
 rtl/shift_restore.sv | 131 +++++++++++++
 tb/tb_shift_restore.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_restore.sv
// shift_restore: walks a forward-shifted/rotated word back by the same amount,
// moving at most STEP positions per cycle between two valid/ready handshakes.

module cnt_bits #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 3,
  parameter bit ACT   = 1'b1
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] count
);
  assign count = OUT_W'($countones(ACT ? in : ~in));
endmodule

module shift_restore #(
  parameter bit BIT_VEC  = 1'b1,
  parameter bit ROTATE   = 1'b0,
  parameter bit TO_RIGHT = 1'b0,
  parameter int DATA     = 8,
  parameter int SHAMT    = 4,
  parameter bit ACT      = 1'b1,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATA-1:0]  in,
  input  logic [SHAMT-1:0] shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA-1:0]  out,
  output logic             busy
);
  localparam int SNUM      = BIT_VEC ? $clog2(SHAMT) + 1 : SHAMT;
  localparam int CW        = $clog2(DATA + 1);
  localparam int RW        = (CW > SNUM) ? CW : SNUM;
  localparam int KW        = $clog2(STEP + 1);
  localparam bit DATA_POW2 = (DATA & (DATA - 1)) == 0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [DATA-1:0] data_reg, data_next;
  logic [RW-1:0]   rem_reg, rem_next;

  logic [SNUM-1:0] amount;
  logic [RW-1:0]   amt_ext;
  logic [RW-1:0]   eff;
  logic [KW-1:0]   k;
  logic [DATA-1:0] fill;
  logic [DATA-1:0] step_data;

  generate
    if (BIT_VEC) begin : g_vec
      cnt_bits #(
        .WIDTH (SHAMT),
        .OUT_W (SNUM),
        .ACT   (ACT)
      ) u_cnt (
        .in    (shamt),
        .count (amount)
      );
    end else begin : g_idx
      assign amount = shamt;
    end
  endgenerate

  assign amt_ext = RW'(amount);

  // Rotates by a multiple of a power-of-two width are identities, so only the
  // residue is walked; other widths simply iterate the full amount.
  always_comb begin
    eff = amt_ext;
    if (ROTATE) begin
      if (DATA_POW2) eff = amt_ext & RW'(DATA - 1);
    end else if (amt_ext > RW'(DATA)) begin
      eff = RW'(DATA);
    end
  end

  // The shifter only needs to span 0..STEP, so k is kept narrow.
  assign k         = (rem_reg < RW'(STEP)) ? KW'(rem_reg) : KW'(STEP);
  assign fill      = ROTATE ? data_reg : '0;
  assign step_data = TO_RIGHT ? DATA'(({data_reg, fill} << k) >> DATA)
                              : DATA'({fill, data_reg} >> k);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_next  = in;
          rem_next   = eff;
          state_next = (eff != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        data_next = step_data;
        rem_next  = rem_reg - RW'(k);
        if (rem_reg == RW'(k)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out  = data_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_restore.sv
// Scoreboard bench for shift_restore: five instances cover the shift/rotate,
// direction, amount-encoding and STEP variants; each is exercised in turn.

module tb_shift_restore;
  localparam int N = 5;
  // Per instance (index 0 is the rightmost bit / element).
  localparam logic [N-1:0]      ROT_V  = 5'b01101;
  localparam logic [N-1:0]      TOR_V  = 5'b11000;
  localparam logic [N-1:0]      BV_V   = 5'b01001;
  localparam logic [N-1:0]      ACT_V  = 5'b10111;
  localparam logic [N-1:0][3:0] STEP_V = {4'd2, 4'd3, 4'd4, 4'd1, 4'd1};

  typedef logic [2:0] idx_t;
  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_v  [N];
  logic       in_ready_v  [N];
  logic [7:0] in_v        [N];
  logic [3:0] shamt_v     [N];
  logic       out_valid_v [N];
  logic       out_ready_v [N];
  logic [7:0] out_v       [N];
  logic       busy_v      [N];

  exp_t sb[$];
  idx_t cur = '0;
  bit   in_flight = 1'b0;
  bit   seen = 1'b0;
  int   run_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    shift_restore #(
      .BIT_VEC  (BV_V[gi]),
      .ROTATE   (ROT_V[gi]),
      .TO_RIGHT (TOR_V[gi]),
      .DATA     (8),
      .SHAMT    (4),
      .ACT      (ACT_V[gi]),
      .STEP     (int'(STEP_V[gi]))
    ) u_dut (
      .clk       (clk),
      .reset_    (rst_n),
      .in_valid  (in_valid_v[gi]),
      .in_ready  (in_ready_v[gi]),
      .in        (in_v[gi]),
      .shamt     (shamt_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .out       (out_v[gi]),
      .busy      (busy_v[gi])
    );
  end

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference: single-position moves repeated, independent of STEP.
  function automatic int eff_of(idx_t d, logic [3:0] sa);
    int a;
    a = BV_V[d] ? (ACT_V[d] ? $countones(sa) : $countones(~sa)) : int'(sa);
    if (ROT_V[d]) a = a % 8;
    else if (a > 8) a = 8;
    return a;
  endfunction

  function automatic logic [7:0] undo(idx_t d, logic [7:0] x, int a);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < a; i++) begin
      if (ROT_V[d]) y = TOR_V[d] ? {y[6:0], y[7]} : {y[0], y[7:1]};
      else          y = TOR_V[d] ? {y[6:0], 1'b0} : {1'b0, y[7:1]};
    end
    return y;
  endfunction

  // Monitor: tracks the active instance, checks latency and output under out_valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_flight = 1'b0;
      sb.delete();
    end else begin
      if (in_flight) begin
        run_cnt++;
        check_val("busy_in_flight", 32'(busy_v[cur]), 1);
        check_val("in_ready_in_flight", 32'(in_ready_v[cur]), 0);
        if (seen) check_val("out_valid_hold", 32'(out_valid_v[cur]), 1);
        if (out_valid_v[cur]) begin
          if (sb.size() == 0) begin
            check_val("sb_size", 32'(sb.size()), 1);
            in_flight = 1'b0;
          end else begin
            if (!seen) begin
              seen = 1'b1;
              check_val("latency", run_cnt, sb[0].lat);
            end
            check_val("out", 32'(out_v[cur]), 32'(sb[0].data));
            if (out_ready_v[cur]) begin
              $display("dut%0d out=%02h first_valid=%0d done_at=%0d", cur, out_v[cur], sb[0].lat, run_cnt);
              void'(sb.pop_front());
              in_flight = 1'b0;
            end
          end
        end
      end
      if (in_valid_v[cur] && in_ready_v[cur]) begin
        if (in_flight) check_val("overlap_accept", 32'(in_flight), 0);
        in_flight = 1'b1;
        seen      = 1'b0;
        run_cnt   = 0;
      end
    end
  end

  task automatic start_op(idx_t d, logic [7:0] din, logic [3:0] sa, logic [7:0] exp_d, int exp_lat);
    int n;
    n   = 0;
    cur = d;
    sb.push_back('{data: exp_d, lat: exp_lat});
    in_v[d] = din;
    shamt_v[d] = sa;
    in_valid_v[d] = 1'b1;
    while (!in_ready_v[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("accept_wait", 32'(in_ready_v[d]), 1);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    shamt_v[d] = 4'bxxxx;
    in_v[d] = 8'hxx;
  endtask

  task automatic finish_op(idx_t d, int bp);
    int n;
    n = 0;
    while (!out_valid_v[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("valid_wait", 32'(out_valid_v[d]), 1);
    repeat (bp) begin
      @(posedge clk); #1;
    end
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
  endtask

  task automatic op(idx_t d, logic [7:0] din, logic [3:0] sa, logic [7:0] exp_d, int exp_lat, int bp);
    start_op(d, din, sa, exp_d, exp_lat);
    finish_op(d, bp);
  endtask

  task automatic model_op(idx_t d, logic [7:0] din, logic [3:0] sa, int bp);
    int a;
    int st;
    a  = eff_of(d, sa);
    st = int'(STEP_V[d]);
    op(d, din, sa, undo(d, din, a), (a + st - 1) / st + 1, bp);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_v  = '{default: 1'b0};
    out_ready_v = '{default: 1'b0};
    in_v        = '{default: 8'h00};
    shamt_v     = '{default: 4'h0};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      cur = idx_t'(i);
      check_val("rst_in_ready", 32'(in_ready_v[cur]), 1);
      check_val("rst_out_valid", 32'(out_valid_v[cur]), 0);
      check_val("rst_busy", 32'(busy_v[cur]), 0);
      check_val("rst_out", 32'(out_v[cur]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-derived results.
    op(3'd0, 8'hB4, 4'b0101, 8'h2D, 3, 0);
    op(3'd0, 8'hA5, 4'b0000, 8'hA5, 1, 0);
    op(3'd1, 8'hF0, 4'd3,    8'h1E, 4, 0);
    op(3'd1, 8'hF0, 4'd15,   8'h00, 9, 1);
    op(3'd1, 8'hA5, 4'd0,    8'hA5, 1, 0);
    op(3'd2, 8'h81, 4'd6,    8'h06, 3, 0);
    op(3'd2, 8'h81, 4'd12,   8'h18, 2, 2);
    op(3'd3, 8'h81, 4'b0001, 8'h0C, 2, 0);
    op(3'd4, 8'h0F, 4'd3,    8'h78, 3, 0);

    // Backpressure with the next operand already waiting.
    cur = 3'd1;
    sb.push_back('{data: 8'h1E, lat: 4});
    in_v[1] = 8'hF0;
    shamt_v[1] = 4'd3;
    in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{data: 8'h0F, lat: 3});
    in_v[1] = 8'h3C;
    shamt_v[1] = 4'd2;
    begin
      int n;
      n = 0;
      while (!out_valid_v[1] && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check_val("bp_valid_wait", 32'(out_valid_v[1]), 1);
    end
    repeat (5) begin
      @(posedge clk); #1;
      check_val("bp_in_ready", 32'(in_ready_v[1]), 0);
    end
    out_ready_v[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[1] = 1'b0;
    check_val("bp_idle_next", 32'(in_ready_v[1]), 1);
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    finish_op(3'd1, 0);

    // Asynchronous reset in the middle of RUN.
    start_op(3'd1, 8'h5A, 4'd10, 8'h00, 9);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", 32'(out_valid_v[1]), 0);
    check_val("abort_busy", 32'(busy_v[1]), 0);
    check_val("abort_in_ready", 32'(in_ready_v[1]), 1);
    check_val("abort_out", 32'(out_v[1]), 0);
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(3'd1, 8'hC3, 4'd2, 8'h30, 3, 0);

    // Random operands on every instance against the reference.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 10; j++) begin
        model_op(idx_t'(i), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
      end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
